// File: rtl/riscv_definitions_pkg.sv
// Shared RISC-V definitions: load/store funct3 encodings and memory arbiter types.
// Access size lives in funct3[1:0] for both loads and stores.
package riscv_definitions;

    typedef enum logic [2:0] {
        F3_LB  = 3'b000,
        F3_LH  = 3'b001,
        F3_LW  = 3'b010,
        F3_LBU = 3'b100,
        F3_LHU = 3'b101
    } funct3_Type_LOAD;

    typedef enum logic [2:0] {
        F3_SB = 3'b000,
        F3_SH = 3'b001,
        F3_SW = 3'b010
    } funct3_Type_STORE;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_REQ,
        ARB_WAIT,
        ARB_ERR
    } arb_state_e;

    typedef enum logic {
        OWN_IF,
        OWN_LSU
    } mem_owner_e;

    localparam int MEM_DATA_WIDTH = 32;
    localparam int BE_WIDTH       = MEM_DATA_WIDTH / 8;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;

    function automatic logic [1:0] access_size(input logic [2:0] funct3);
        return funct3[1:0];
    endfunction

endpackage

// File: rtl/riscv_mem_arbiter_align.sv
// Byte-lane alignment for the LSU: store-side byte enables / data replication /
// misalignment detection, and load-side lane extraction with sign/zero extension.
module riscv_lsu_align
    import riscv_definitions::*;
(
    input  logic [2:0]          st_funct3,
    input  logic [1:0]          st_off,
    input  logic [31:0]         st_wdata,
    output logic [BE_WIDTH-1:0] st_be,
    output logic [31:0]         st_wdata_rep,
    output logic                st_misaligned,
    input  logic [2:0]          ld_funct3,
    input  logic [1:0]          ld_off,
    input  logic [31:0]         ld_rdata,
    output logic [31:0]         ld_rdata_ext
);
    logic [1:0]  st_size;
    logic [1:0]  ld_size;
    logic [31:0] ld_shifted;
    logic        ld_sext;
    logic        unused_st_sign;

    assign st_size        = access_size(st_funct3);
    assign ld_size        = access_size(ld_funct3);
    assign ld_sext        = ~ld_funct3[2];
    assign unused_st_sign = st_funct3[2];

    // Anything that is not byte or half is treated as a full word.
    always_comb begin
        st_be         = '1;
        st_misaligned = 1'b0;
        case (st_size)
            SIZE_BYTE: st_be = 4'b0001 << st_off;
            SIZE_HALF: begin
                st_be         = 4'b0011 << st_off;
                st_misaligned = st_off[0];
            end
            default:   st_misaligned = (st_off != 2'b00);
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < BE_WIDTH; gi++) begin : g_lane
            assign st_wdata_rep[8*gi +: 8] =
                (st_size == SIZE_BYTE) ? st_wdata[7:0] :
                (st_size == SIZE_HALF) ? st_wdata[8*(gi%2) +: 8] :
                                         st_wdata[8*gi +: 8];
        end
    endgenerate

    assign ld_shifted = ld_rdata >> {ld_off, 3'b000};

    always_comb begin
        case (ld_size)
            SIZE_BYTE: ld_rdata_ext = {{24{ld_sext & ld_shifted[7]}}, ld_shifted[7:0]};
            SIZE_HALF: ld_rdata_ext = {{16{ld_sext & ld_shifted[15]}}, ld_shifted[15:0]};
            default:   ld_rdata_ext = ld_shifted;
        endcase
    end

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Shares one memory port between instruction fetch and the LSU, one transaction
// in flight at a time; misaligned LSU accesses are answered locally with err.
module riscv_mem_arbiter
    import riscv_definitions::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_req_i,
    input  logic [ADDR_WIDTH-1:0] if_addr_i,
    output logic                  if_gnt_o,
    output logic                  if_rvalid_o,
    output logic [DATA_WIDTH-1:0] if_rdata_o,
    input  logic                  lsu_req_i,
    input  logic                  lsu_we_i,
    input  logic [2:0]            lsu_funct3_i,
    input  logic [ADDR_WIDTH-1:0] lsu_addr_i,
    input  logic [DATA_WIDTH-1:0] lsu_wdata_i,
    output logic                  lsu_gnt_o,
    output logic                  lsu_rvalid_o,
    output logic [DATA_WIDTH-1:0] lsu_rdata_o,
    output logic                  lsu_err_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [BE_WIDTH-1:0]   mem_be_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);
    arb_state_e            state_reg, state_next;
    mem_owner_e            owner_reg;
    logic                  last_lsu_reg;
    logic                  we_reg;
    logic [BE_WIDTH-1:0]   be_reg;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [DATA_WIDTH-1:0] wdata_reg;
    logic [2:0]            funct3_reg;
    logic [1:0]            off_reg;

    logic                  grant_lsu, grant_if;
    logic [BE_WIDTH-1:0]   st_be;
    logic [DATA_WIDTH-1:0] st_wdata_rep;
    logic                  st_misaligned;
    logic [DATA_WIDTH-1:0] ld_rdata_ext;
    logic                  unused_if_offset;

    assign unused_if_offset = ^if_addr_i[1:0];

    riscv_lsu_align u_align (
        .st_funct3     (lsu_funct3_i),
        .st_off        (lsu_addr_i[1:0]),
        .st_wdata      (lsu_wdata_i),
        .st_be         (st_be),
        .st_wdata_rep  (st_wdata_rep),
        .st_misaligned (st_misaligned),
        .ld_funct3     (funct3_reg),
        .ld_off        (off_reg),
        .ld_rdata      (mem_rdata_i),
        .ld_rdata_ext  (ld_rdata_ext)
    );

    // LSU wins unless it also took the previous grant while IF is waiting.
    always_comb begin
        grant_lsu = 1'b0;
        grant_if  = 1'b0;
        if (rst_n && state_reg == ARB_IDLE) begin
            grant_lsu = lsu_req_i && !(if_req_i && last_lsu_reg);
            grant_if  = if_req_i && !grant_lsu;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_reg <= ARB_IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ARB_IDLE: begin
                if (grant_lsu)     state_next = st_misaligned ? ARB_ERR : ARB_REQ;
                else if (grant_if) state_next = ARB_REQ;
            end
            ARB_REQ:  if (mem_gnt_i)    state_next = ARB_WAIT;
            ARB_WAIT: if (mem_rvalid_i) state_next = ARB_IDLE;
            default:  state_next = ARB_IDLE;
        endcase
    end

    always_comb begin
        if_gnt_o     = grant_if;
        lsu_gnt_o    = grant_lsu;
        mem_req_o    = (state_reg == ARB_REQ);
        if_rvalid_o  = 1'b0;
        lsu_rvalid_o = 1'b0;
        lsu_err_o    = 1'b0;
        lsu_rdata_o  = '0;
        if (rst_n) begin
            case (state_reg)
                ARB_WAIT: begin
                    if (mem_rvalid_i) begin
                        if (owner_reg == OWN_IF) begin
                            if_rvalid_o = 1'b1;
                        end else begin
                            lsu_rvalid_o = 1'b1;
                            if (!we_reg) lsu_rdata_o = ld_rdata_ext;
                        end
                    end
                end
                ARB_ERR: begin
                    lsu_rvalid_o = 1'b1;
                    lsu_err_o    = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Captured request fields stay frozen while the memory side stalls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            owner_reg    <= OWN_IF;
            last_lsu_reg <= 1'b0;
            we_reg       <= 1'b0;
            be_reg       <= '0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            funct3_reg   <= '0;
            off_reg      <= '0;
        end else begin
            if (grant_lsu || grant_if) last_lsu_reg <= grant_lsu;
            if (grant_if) begin
                owner_reg  <= OWN_IF;
                we_reg     <= 1'b0;
                be_reg     <= '1;
                addr_reg   <= {if_addr_i[ADDR_WIDTH-1:2], 2'b00};
                wdata_reg  <= '0;
                funct3_reg <= F3_LW;
                off_reg    <= 2'b00;
            end else if (grant_lsu && !st_misaligned) begin
                owner_reg  <= OWN_LSU;
                we_reg     <= lsu_we_i;
                be_reg     <= st_be;
                addr_reg   <= {lsu_addr_i[ADDR_WIDTH-1:2], 2'b00};
                wdata_reg  <= st_wdata_rep;
                funct3_reg <= lsu_funct3_i;
                off_reg    <= lsu_addr_i[1:0];
            end
        end
    end

    assign mem_we_o    = we_reg;
    assign mem_be_o    = be_reg;
    assign mem_addr_o  = addr_reg;
    assign mem_wdata_o = wdata_reg;
    assign if_rdata_o  = mem_rdata_i;

    a_no_gnt_with_rvalid: assert property (@(posedge clk) disable iff (!rst_n)
        !(mem_gnt_i && mem_rvalid_i));

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Directed self-checking bench for riscv_mem_arbiter: handshake latency, lane
// alignment, misalignment, arbitration fairness, memory stall and reset recovery.
module tb_riscv_mem_arbiter;
    import riscv_definitions::*;

    logic        clk;
    logic        rst_n;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        if_gnt_o, if_rvalid_o;
    logic [31:0] if_rdata_o;
    logic        lsu_req_i, lsu_we_i;
    logic [2:0]  lsu_funct3_i;
    logic [31:0] lsu_addr_i, lsu_wdata_i;
    logic        lsu_gnt_o, lsu_rvalid_o, lsu_err_o;
    logic [31:0] lsu_rdata_o;
    logic        mem_req_o, mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_gnt_i, mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    int checks = 0;
    int errors = 0;

    riscv_mem_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .if_req_i     (if_req_i),
        .if_addr_i    (if_addr_i),
        .if_gnt_o     (if_gnt_o),
        .if_rvalid_o  (if_rvalid_o),
        .if_rdata_o   (if_rdata_o),
        .lsu_req_i    (lsu_req_i),
        .lsu_we_i     (lsu_we_i),
        .lsu_funct3_i (lsu_funct3_i),
        .lsu_addr_i   (lsu_addr_i),
        .lsu_wdata_i  (lsu_wdata_i),
        .lsu_gnt_o    (lsu_gnt_o),
        .lsu_rvalid_o (lsu_rvalid_o),
        .lsu_rdata_o  (lsu_rdata_o),
        .lsu_err_o    (lsu_err_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_be_o     (mem_be_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One full LSU transaction with a zero-wait memory: gnt at N, mem_gnt at N+1, rvalid at N+2.
    task automatic run_lsu(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rresp,
                           output logic g, output logic mreq, output logic mwe,
                           output logic [3:0] mbe, output logic [31:0] maddr,
                           output logic [31:0] mwdata, output logic rv,
                           output logic [31:0] rd, output logic er);
        lsu_req_i = 1'b1; lsu_we_i = we; lsu_funct3_i = f3;
        lsu_addr_i = addr; lsu_wdata_i = wdata;
        #1 g = lsu_gnt_o;
        tick;
        lsu_req_i = 1'b0; mem_gnt_i = 1'b1;
        #1 mreq = mem_req_o; mwe = mem_we_o; mbe = mem_be_o; maddr = mem_addr_o; mwdata = mem_wdata_o;
        tick;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = rresp;
        #1 rv = lsu_rvalid_o; rd = lsu_rdata_o; er = lsu_err_o;
        tick;
        mem_rvalid_i = 1'b0;
        $display("txn lsu we=%0b f3=%0d addr=%h gnt=%0b be=%b maddr=%h wdata=%h rvalid=%0b rdata=%h",
                 we, f3, addr, g, mbe, maddr, mwdata, rv, rd);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick;
        tick;
        if_req_i = 1'b1; lsu_req_i = 1'b1; mem_rvalid_i = 1'b1;
        #1;
        checks++; if (if_gnt_o !== 1'b0) begin errors++; $display("FAIL reset_if_gnt got %b want 0", if_gnt_o); end
        checks++; if (lsu_gnt_o !== 1'b0) begin errors++; $display("FAIL reset_lsu_gnt got %b want 0", lsu_gnt_o); end
        checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %b want 0", mem_req_o); end
        checks++; if (mem_be_o !== 4'b0000) begin errors++; $display("FAIL reset_mem_be got %b want 0000", mem_be_o); end
        checks++; if (mem_addr_o !== 32'h0) begin errors++; $display("FAIL reset_mem_addr got %h want 0", mem_addr_o); end
        checks++; if ({if_rvalid_o, lsu_rvalid_o} !== 2'b00) begin errors++; $display("FAIL reset_rvalid got %b want 00", {if_rvalid_o, lsu_rvalid_o}); end
        if_req_i = 1'b0; lsu_req_i = 1'b0; mem_rvalid_i = 1'b0;
        tick;
        rst_n = 1'b1;
        $display("txn reset done");
    endtask

    task automatic test_lw;
        logic g, mreq, mwe, rv, er;
        logic [3:0] mbe;
        logic [31:0] maddr, mwdata, rd;
        run_lsu(1'b0, F3_LW, 32'h100, 32'h0, 32'hDEADBEEF, g, mreq, mwe, mbe, maddr, mwdata, rv, rd, er);
        checks++; if (g !== 1'b1) begin errors++; $display("FAIL lw_gnt got %b want 1", g); end
        checks++; if (mreq !== 1'b1 || mwe !== 1'b0) begin errors++; $display("FAIL lw_mem_req got req=%b we=%b want req=1 we=0", mreq, mwe); end
        checks++; if (maddr !== 32'h100) begin errors++; $display("FAIL lw_addr got %h want 00000100", maddr); end
        checks++; if (mbe !== 4'b1111) begin errors++; $display("FAIL lw_be got %b want 1111", mbe); end
        checks++; if (rv !== 1'b1 || er !== 1'b0) begin errors++; $display("FAIL lw_rvalid got rv=%b err=%b want rv=1 err=0", rv, er); end
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_rdata got %h want deadbeef", rd); end
    endtask

    task automatic test_byte_half;
        logic g, mreq, mwe, rv, er;
        logic [3:0] mbe;
        logic [31:0] maddr, mwdata, rd;
        run_lsu(1'b1, F3_SB, 32'h203, 32'h000000A5, 32'h12345678, g, mreq, mwe, mbe, maddr, mwdata, rv, rd, er);
        checks++; if (mbe !== 4'b1000 || mwe !== 1'b1) begin errors++; $display("FAIL sb_be got be=%b we=%b want be=1000 we=1", mbe, mwe); end
        checks++; if (mwdata !== 32'hA5A5A5A5) begin errors++; $display("FAIL sb_wdata got %h want a5a5a5a5", mwdata); end
        checks++; if (maddr !== 32'h200) begin errors++; $display("FAIL sb_addr got %h want 00000200", maddr); end
        checks++; if (rv !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL sb_ack got rv=%b rdata=%h want rv=1 rdata=0", rv, rd); end
        run_lsu(1'b0, F3_LB, 32'h203, 32'h0, 32'h80112233, g, mreq, mwe, mbe, maddr, mwdata, rv, rd, er);
        checks++; if (mbe !== 4'b1000) begin errors++; $display("FAIL lb_be got %b want 1000", mbe); end
        checks++; if (rd !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_rdata got %h want ffffff80", rd); end
        run_lsu(1'b0, F3_LBU, 32'h203, 32'h0, 32'h80112233, g, mreq, mwe, mbe, maddr, mwdata, rv, rd, er);
        checks++; if (rd !== 32'h00000080) begin errors++; $display("FAIL lbu_rdata got %h want 00000080", rd); end
        run_lsu(1'b1, F3_SH, 32'h102, 32'h1234BEEF, 32'h0, g, mreq, mwe, mbe, maddr, mwdata, rv, rd, er);
        checks++; if (mbe !== 4'b1100) begin errors++; $display("FAIL sh_be got %b want 1100", mbe); end
        checks++; if (mwdata !== 32'hBEEFBEEF) begin errors++; $display("FAIL sh_wdata got %h want beefbeef", mwdata); end
        run_lsu(1'b0, F3_LH, 32'h102, 32'h0, 32'h80112233, g, mreq, mwe, mbe, maddr, mwdata, rv, rd, er);
        checks++; if (rd !== 32'hFFFF8011) begin errors++; $display("FAIL lh_rdata got %h want ffff8011", rd); end
        run_lsu(1'b0, F3_LHU, 32'h102, 32'h0, 32'h80112233, g, mreq, mwe, mbe, maddr, mwdata, rv, rd, er);
        checks++; if (rd !== 32'h00008011) begin errors++; $display("FAIL lhu_rdata got %h want 00008011", rd); end
    endtask

    task automatic test_misaligned;
        logic [2:0]  f3_tab [2];
        logic [31:0] addr_tab [2];
        f3_tab[0] = F3_LH; addr_tab[0] = 32'h101;
        f3_tab[1] = F3_SW; addr_tab[1] = 32'h102;
        for (int i = 0; i < 2; i++) begin
            lsu_req_i = 1'b1; lsu_we_i = (i == 1); lsu_funct3_i = f3_tab[i];
            lsu_addr_i = addr_tab[i]; lsu_wdata_i = 32'hFFFFFFFF;
            #1;
            checks++; if (lsu_gnt_o !== 1'b1) begin errors++; $display("FAIL mis%0d_gnt got %b want 1", i, lsu_gnt_o); end
            tick;
            lsu_req_i = 1'b0;
            #1;
            checks++; if (lsu_rvalid_o !== 1'b1 || lsu_err_o !== 1'b1) begin errors++; $display("FAIL mis%0d_err got rv=%b err=%b want 1 1", i, lsu_rvalid_o, lsu_err_o); end
            checks++; if (lsu_rdata_o !== 32'h0) begin errors++; $display("FAIL mis%0d_rdata got %h want 0", i, lsu_rdata_o); end
            checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL mis%0d_memreq got %b want 0", i, mem_req_o); end
            tick;
            checks++; if (lsu_rvalid_o !== 1'b0 || mem_req_o !== 1'b0) begin errors++; $display("FAIL mis%0d_after got rv=%b req=%b want 0 0", i, lsu_rvalid_o, mem_req_o); end
            $display("txn misaligned f3=%0d addr=%h", f3_tab[i], addr_tab[i]);
        end
    endtask

    task automatic test_if_fetch;
        if_req_i = 1'b1; if_addr_i = 32'h407;
        #1;
        checks++; if (if_gnt_o !== 1'b1 || lsu_gnt_o !== 1'b0) begin errors++; $display("FAIL if_gnt got if=%b lsu=%b want 1 0", if_gnt_o, lsu_gnt_o); end
        tick;
        if_req_i = 1'b0; mem_gnt_i = 1'b1;
        #1;
        checks++; if (mem_addr_o !== 32'h404) begin errors++; $display("FAIL if_addr got %h want 00000404", mem_addr_o); end
        checks++; if (mem_be_o !== 4'b1111 || mem_we_o !== 1'b0 || mem_req_o !== 1'b1) begin errors++; $display("FAIL if_fields got be=%b we=%b req=%b want 1111 0 1", mem_be_o, mem_we_o, mem_req_o); end
        tick;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hCAFEF00D;
        #1;
        checks++; if (if_rvalid_o !== 1'b1 || lsu_rvalid_o !== 1'b0) begin errors++; $display("FAIL if_rvalid got if=%b lsu=%b want 1 0", if_rvalid_o, lsu_rvalid_o); end
        checks++; if (if_rdata_o !== 32'hCAFEF00D) begin errors++; $display("FAIL if_rdata got %h want cafef00d", if_rdata_o); end
        tick;
        mem_rvalid_i = 1'b0;
        $display("txn if fetch addr=00000407");
    endtask

    task automatic test_alternate;
        logic exp_lsu;
        if_req_i = 1'b1; if_addr_i = 32'h400;
        lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_funct3_i = F3_LW; lsu_addr_i = 32'h300;
        for (int i = 0; i < 4; i++) begin
            exp_lsu = (i % 2 == 0);
            #1;
            checks++; if (lsu_gnt_o !== exp_lsu || if_gnt_o !== !exp_lsu) begin errors++; $display("FAIL alt%0d_gnt got lsu=%b if=%b want lsu=%b", i, lsu_gnt_o, if_gnt_o, exp_lsu); end
            tick;
            mem_gnt_i = 1'b1;
            #1;
            checks++; if (lsu_gnt_o !== 1'b0 || if_gnt_o !== 1'b0) begin errors++; $display("FAIL alt%0d_busy_gnt got lsu=%b if=%b want 0 0", i, lsu_gnt_o, if_gnt_o); end
            checks++; if (mem_addr_o !== (exp_lsu ? 32'h300 : 32'h400)) begin errors++; $display("FAIL alt%0d_addr got %h", i, mem_addr_o); end
            tick;
            mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1000 + i;
            #1;
            checks++; if (lsu_rvalid_o !== exp_lsu || if_rvalid_o !== !exp_lsu) begin errors++; $display("FAIL alt%0d_rvalid got lsu=%b if=%b want lsu=%b", i, lsu_rvalid_o, if_rvalid_o, exp_lsu); end
            tick;
            mem_rvalid_i = 1'b0;
            $display("txn alternate %0d owner=%s", i, exp_lsu ? "lsu" : "if");
        end
        if_req_i = 1'b0; lsu_req_i = 1'b0;
    endtask

    task automatic test_lsu_alone;
        logic g, mreq, mwe, rv, er;
        logic [3:0] mbe;
        logic [31:0] maddr, mwdata, rd;
        for (int i = 0; i < 2; i++) begin
            run_lsu(1'b0, F3_LW, 32'h800 + 4 * i, 32'h0, 32'h0, g, mreq, mwe, mbe, maddr, mwdata, rv, rd, er);
            checks++; if (g !== 1'b1 || maddr !== 32'h800 + 4 * i) begin errors++; $display("FAIL lsu_alone%0d got gnt=%b addr=%h", i, g, maddr); end
        end
    endtask

    task automatic test_stall;
        lsu_req_i = 1'b1; lsu_we_i = 1'b1; lsu_funct3_i = F3_SW;
        lsu_addr_i = 32'h500; lsu_wdata_i = 32'h11223344;
        #1;
        checks++; if (lsu_gnt_o !== 1'b1) begin errors++; $display("FAIL stall_gnt got %b want 1", lsu_gnt_o); end
        tick;
        lsu_req_i = 1'b0; lsu_addr_i = 32'hFFFFFFFC; lsu_wdata_i = 32'h0; if_req_i = 1'b1; if_addr_i = 32'h900;
        for (int k = 0; k < 5; k++) begin
            mem_rvalid_i = (k == 2);
            #1;
            checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h500 || mem_be_o !== 4'b1111 || mem_we_o !== 1'b1 || mem_wdata_o !== 32'h11223344) begin
                errors++; $display("FAIL stall%0d_fields got req=%b addr=%h be=%b we=%b wdata=%h", k, mem_req_o, mem_addr_o, mem_be_o, mem_we_o, mem_wdata_o);
            end
            checks++; if (if_gnt_o !== 1'b0 || lsu_gnt_o !== 1'b0 || lsu_rvalid_o !== 1'b0) begin errors++; $display("FAIL stall%0d_quiet got ifg=%b lsug=%b rv=%b want 0 0 0", k, if_gnt_o, lsu_gnt_o, lsu_rvalid_o); end
            tick;
        end
        mem_rvalid_i = 1'b0; mem_gnt_i = 1'b1; if_req_i = 1'b0;
        tick;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hABCD0123;
        #1;
        checks++; if (lsu_rvalid_o !== 1'b1 || lsu_rdata_o !== 32'h0) begin errors++; $display("FAIL stall_ack got rv=%b rdata=%h want 1 0", lsu_rvalid_o, lsu_rdata_o); end
        tick;
        mem_rvalid_i = 1'b0;
        $display("txn stalled sw addr=00000500 wdata=11223344");
    endtask

    task automatic test_reset_mid;
        if_req_i = 1'b1; if_addr_i = 32'h600;
        #1;
        checks++; if (if_gnt_o !== 1'b1) begin errors++; $display("FAIL rmid_gnt got %b want 1", if_gnt_o); end
        tick;
        if_req_i = 1'b0; mem_gnt_i = 1'b1;
        tick;
        mem_gnt_i = 1'b0; rst_n = 1'b0; if_req_i = 1'b1; if_addr_i = 32'h700;
        #1;
        checks++; if (if_gnt_o !== 1'b0) begin errors++; $display("FAIL rmid_gnt_in_reset got %b want 0", if_gnt_o); end
        tick;
        rst_n = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h55555555;
        #1;
        checks++; if (if_rvalid_o !== 1'b0) begin errors++; $display("FAIL rmid_late_rvalid got %b want 0", if_rvalid_o); end
        checks++; if (if_gnt_o !== 1'b1) begin errors++; $display("FAIL rmid_regrant got %b want 1", if_gnt_o); end
        checks++; if (mem_req_o !== 1'b0 || mem_addr_o !== 32'h0) begin errors++; $display("FAIL rmid_cleared got req=%b addr=%h want 0 0", mem_req_o, mem_addr_o); end
        tick;
        mem_rvalid_i = 1'b0; if_req_i = 1'b0; mem_gnt_i = 1'b1;
        #1;
        checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h700) begin errors++; $display("FAIL rmid_newreq got req=%b addr=%h want 1 00000700", mem_req_o, mem_addr_o); end
        tick;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h77777777;
        #1;
        checks++; if (if_rvalid_o !== 1'b1 || if_rdata_o !== 32'h77777777) begin errors++; $display("FAIL rmid_resp got rv=%b rdata=%h want 1 77777777", if_rvalid_o, if_rdata_o); end
        tick;
        mem_rvalid_i = 1'b0;
        $display("txn reset mid-transaction, refetch addr=00000700");
    endtask

    initial begin
        rst_n = 1'b0;
        if_req_i = 1'b0; if_addr_i = '0;
        lsu_req_i = 1'b0; lsu_we_i = 1'b0; lsu_funct3_i = '0; lsu_addr_i = '0; lsu_wdata_i = '0;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
        test_reset;
        test_lw;
        test_byte_half;
        test_misaligned;
        test_if_fetch;
        test_alternate;
        test_lsu_alone;
        test_stall;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
